// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit:
// FSM states, ALU operation codes, opcodes and datapath select values.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_ADDR,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_WB_ALU,
    ST_WB_MEM,
    ST_BRANCH,
    ST_JAL,
    ST_JALR,
    ST_LUI,
    ST_AUIPC,
    ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [1:0] SRCA_PC     = 2'd0;
  localparam logic [1:0] SRCA_OLDPC  = 2'd1;
  localparam logic [1:0] SRCA_RS1    = 2'd2;
  localparam logic [1:0] SRCA_ZERO   = 2'd3;

  localparam logic [1:0] SRCB_RS2    = 2'd0;
  localparam logic [1:0] SRCB_IMM    = 2'd1;
  localparam logic [1:0] SRCB_FOUR   = 2'd2;

  localparam logic [1:0] PCSEL_ALU    = 2'd0;
  localparam logic [1:0] PCSEL_ALUOUT = 2'd1;
  localparam logic [1:0] PCSEL_JALR   = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MEMRD  = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

endpackage

// File: rtl/riscv_alu_decode.sv
// Maps funct3/funct7b5 to an ALU operation for register and immediate ALU instructions.
module riscv_alu_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  input  logic       i_is_rtype,
  output logic [3:0] o_alu_op
);

  always_comb begin
    o_alu_op = ALU_ADD;
    case (i_funct3)
      // ADDI has no SUB form; bit 30 is part of the immediate there
      3'b000:  o_alu_op = (i_is_rtype && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  o_alu_op = ALU_SLL;
      3'b010:  o_alu_op = ALU_SLT;
      3'b011:  o_alu_op = ALU_SLTU;
      3'b100:  o_alu_op = ALU_XOR;
      3'b101:  o_alu_op = i_funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  o_alu_op = ALU_OR;
      3'b111:  o_alu_op = ALU_AND;
      default: o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_mc_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory wait states, traps on illegal encodings and counts retired instructions.
//
// state     | meaning
// FETCH     | read instruction, PC += 4 when memory responds
// DECODE    | old_pc + imm latched as branch/JAL target
// EXEC_R    | rs1 op rs2
// EXEC_I    | rs1 op imm
// ADDR      | effective address rs1 + imm
// MEM_RD    | load request, waits for mem_ready
// MEM_WR    | store request, waits for mem_ready, retires
// WB_ALU    | write alu_out to rd, retires
// WB_MEM    | write load data to rd, retires
// BRANCH    | compare rs1/rs2, PC <- target if taken, retires
// JAL       | PC <- target, rd <- PC, retires
// JALR      | PC <- (rs1 + imm) & ~1, rd <- PC, retires
// LUI       | 0 + imm
// AUIPC     | old_pc + imm
// TRAP      | illegal encoding, held until reset
module riscv_mc_control
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             funct7b5,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             ir_we,
  output logic             pc_we,
  output logic             rf_we,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       alu_op,
  output logic [1:0]       pc_sel,
  output logic [1:0]       wb_sel,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  state_t           r_state;
  logic             r_illegal;
  logic [CNT_W-1:0] r_instret;

  logic       w_is_rtype;
  logic [3:0] w_exec_op;
  logic       w_taken;
  logic       w_br_bad;

  logic       w_mem_req, w_mem_we, w_ir_we, w_pc_we, w_rf_we;
  logic [1:0] w_src_a, w_src_b, w_pc_sel, w_wb_sel;
  logic [3:0] w_alu_op;

  assign w_is_rtype = (r_state == ST_EXEC_R);

  riscv_alu_decode u_alu_decode (
    .i_funct3   (funct3),
    .i_funct7b5 (funct7b5),
    .i_is_rtype (w_is_rtype),
    .o_alu_op   (w_exec_op)
  );

  always_comb begin
    w_taken  = 1'b0;
    w_br_bad = 1'b0;
    case (funct3)
      3'b000:  w_taken = alu_zero;
      3'b001:  w_taken = ~alu_zero;
      3'b100:  w_taken = alu_lt;
      3'b101:  w_taken = ~alu_lt;
      3'b110:  w_taken = alu_ltu;
      3'b111:  w_taken = ~alu_ltu;
      default: w_br_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_FETCH;
      r_illegal <= 1'b0;
      r_instret <= '0;
    end else begin
      case (r_state)
        ST_FETCH:  if (mem_ready) r_state <= ST_DECODE;
        ST_DECODE: begin
          case (opcode)
            OP_RTYPE:          r_state <= ST_EXEC_R;
            OP_ITYPE:          r_state <= ST_EXEC_I;
            OP_LOAD, OP_STORE: r_state <= ST_ADDR;
            OP_BRANCH:         r_state <= ST_BRANCH;
            OP_JAL:            r_state <= ST_JAL;
            OP_JALR:           r_state <= ST_JALR;
            OP_LUI:            r_state <= ST_LUI;
            OP_AUIPC:          r_state <= ST_AUIPC;
            default: begin
              r_state   <= ST_TRAP;
              r_illegal <= 1'b1;
            end
          endcase
        end
        ST_EXEC_R, ST_EXEC_I, ST_LUI, ST_AUIPC: r_state <= ST_WB_ALU;
        ST_ADDR:   r_state <= (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
        ST_MEM_RD: if (mem_ready) r_state <= ST_WB_MEM;
        ST_MEM_WR: begin
          if (mem_ready) begin
            r_state   <= ST_FETCH;
            r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WB_ALU, ST_WB_MEM, ST_JAL, ST_JALR: begin
          r_state   <= ST_FETCH;
          r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        ST_BRANCH: begin
          if (w_br_bad) begin
            r_state   <= ST_TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state   <= ST_FETCH;
            r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_TRAP:   r_state <= ST_TRAP;
        default:   r_state <= ST_FETCH;
      endcase
    end
  end

  always_comb begin
    w_mem_req = 1'b0;
    w_mem_we  = 1'b0;
    w_ir_we   = 1'b0;
    w_pc_we   = 1'b0;
    w_rf_we   = 1'b0;
    w_src_a   = SRCA_PC;
    w_src_b   = SRCB_RS2;
    w_alu_op  = ALU_ADD;
    w_pc_sel  = PCSEL_ALU;
    w_wb_sel  = WB_ALUOUT;
    case (r_state)
      ST_FETCH: begin
        w_mem_req = 1'b1;
        w_src_a   = SRCA_PC;
        w_src_b   = SRCB_FOUR;
        w_ir_we   = mem_ready;
        w_pc_we   = mem_ready;
      end
      ST_DECODE: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
      end
      ST_EXEC_R: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_RS2;
        w_alu_op = w_exec_op;
      end
      ST_EXEC_I: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_IMM;
        w_alu_op = w_exec_op;
      end
      ST_LUI: begin
        w_src_a = SRCA_ZERO;
        w_src_b = SRCB_IMM;
      end
      ST_AUIPC: begin
        w_src_a = SRCA_OLDPC;
        w_src_b = SRCB_IMM;
      end
      ST_ADDR: begin
        w_src_a = SRCA_RS1;
        w_src_b = SRCB_IMM;
      end
      ST_MEM_RD: w_mem_req = 1'b1;
      ST_MEM_WR: begin
        w_mem_req = 1'b1;
        w_mem_we  = 1'b1;
      end
      ST_WB_ALU: begin
        w_rf_we  = 1'b1;
        w_wb_sel = WB_ALUOUT;
      end
      ST_WB_MEM: begin
        w_rf_we  = 1'b1;
        w_wb_sel = WB_MEMRD;
      end
      ST_BRANCH: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_RS2;
        w_alu_op = ALU_SUB;
        w_pc_sel = PCSEL_ALUOUT;
        w_pc_we  = w_taken;
      end
      ST_JAL: begin
        w_pc_we  = 1'b1;
        w_pc_sel = PCSEL_ALUOUT;
        w_rf_we  = 1'b1;
        w_wb_sel = WB_PC;
      end
      ST_JALR: begin
        w_src_a  = SRCA_RS1;
        w_src_b  = SRCB_IMM;
        w_pc_sel = PCSEL_JALR;
        w_pc_we  = 1'b1;
        w_rf_we  = 1'b1;
        w_wb_sel = WB_PC;
      end
      default: ;
    endcase
  end

  // Reset is synchronous, so outputs are gated directly to be quiet during the reset cycle itself
  assign mem_req   = w_mem_req & ~reset;
  assign mem_we    = w_mem_we  & ~reset;
  assign ir_we     = w_ir_we   & ~reset;
  assign pc_we     = w_pc_we   & ~reset;
  assign rf_we     = w_rf_we   & ~reset;
  assign alu_src_a = reset ? 2'd0 : w_src_a;
  assign alu_src_b = reset ? 2'd0 : w_src_b;
  assign alu_op    = reset ? 4'd0 : w_alu_op;
  assign pc_sel    = reset ? 2'd0 : w_pc_sel;
  assign wb_sel    = reset ? 2'd0 : w_wb_sel;
  assign illegal   = r_illegal & ~reset;
  assign instret   = reset ? '0 : r_instret;

endmodule

// File: tb/tb_riscv_mc_control.sv
// Randomized bench: per-instruction expected output traces built from instruction classes.
module tb_riscv_mc_control;

  localparam int CW = 4;

  localparam int C_R = 0, C_I = 1, C_LUI = 2, C_AUIPC = 3, C_LOAD = 4,
                 C_STORE = 5, C_BR = 6, C_JAL = 7, C_JALR = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          funct7b5;
  logic          alu_zero, alu_lt, alu_ltu;
  logic          mem_ready;
  logic          mem_req, mem_we, ir_we, pc_we, rf_we, illegal;
  logic [1:0]    alu_src_a, alu_src_b, pc_sel, wb_sel;
  logic [3:0]    alu_op;
  logic [CW-1:0] instret;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned model_cnt = 0;
  logic [17:0] q_v[$];
  bit          q_r[$];

  riscv_mc_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_sel(pc_sel),
    .wb_sel(wb_sel), .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [17:0] vec(bit mreq, bit mwe, bit irwe, bit pcwe, bit rfwe, bit ill,
                                      logic [1:0] sa, logic [1:0] sb, logic [3:0] op,
                                      logic [1:0] ps, logic [1:0] wb);
    return {mreq, mwe, irwe, pcwe, rfwe, ill, sa, sb, op, ps, wb};
  endfunction

  function automatic logic [17:0] dut_vec();
    return {mem_req, mem_we, ir_we, pc_we, rf_we, illegal,
            alu_src_a, alu_src_b, alu_op, pc_sel, wb_sel};
  endfunction

  function automatic logic [3:0] ref_alu_op(logic [2:0] f3, bit b5, bit is_r);
    int base[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int r;
    r = base[f3];
    if (f3 == 3'd0 && is_r && b5) r = 1;
    if (f3 == 3'd5 && b5) r = 7;
    return r[3:0];
  endfunction

  function automatic bit ref_taken(logic [2:0] f3, logic [31:0] a, logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return $signed(a) >= $signed(b);
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(int cls);
    case (cls)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LUI:   return 7'b0110111;
      C_AUIPC: return 7'b0010111;
      C_LOAD:  return 7'b0000011;
      C_STORE: return 7'b0100011;
      C_BR:    return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1100111;
    endcase
  endfunction

  task automatic push(input logic [17:0] v, input bit r);
    q_v.push_back(v);
    q_r.push_back(r);
  endtask

  // mem_ready is randomized wherever no request is outstanding; it must be ignored there
  task automatic push_x(input logic [17:0] v);
    push(v, 1'($urandom_range(0, 1)));
  endtask

  task automatic build(input int cls, input logic [2:0] f3, input bit b5, input bit taken,
                       input int fw, input int mw);
    for (int i = 0; i < fw; i++) push(vec(1,0,0,0,0,0, 0,2,0,0,0), 1'b0);
    push(vec(1,0,1,1,0,0, 0,2,0,0,0), 1'b1);
    push_x(vec(0,0,0,0,0,0, 1,1,0,0,0));
    case (cls)
      C_R:     begin push_x(vec(0,0,0,0,0,0, 2,0,ref_alu_op(f3,b5,1),0,0));
                     push_x(vec(0,0,0,0,1,0, 0,0,0,0,0)); end
      C_I:     begin push_x(vec(0,0,0,0,0,0, 2,1,ref_alu_op(f3,b5,0),0,0));
                     push_x(vec(0,0,0,0,1,0, 0,0,0,0,0)); end
      C_LUI:   begin push_x(vec(0,0,0,0,0,0, 3,1,0,0,0));
                     push_x(vec(0,0,0,0,1,0, 0,0,0,0,0)); end
      C_AUIPC: begin push_x(vec(0,0,0,0,0,0, 1,1,0,0,0));
                     push_x(vec(0,0,0,0,1,0, 0,0,0,0,0)); end
      C_LOAD:  begin
        push_x(vec(0,0,0,0,0,0, 2,1,0,0,0));
        for (int i = 0; i < mw; i++) push(vec(1,0,0,0,0,0, 0,0,0,0,0), 1'b0);
        push(vec(1,0,0,0,0,0, 0,0,0,0,0), 1'b1);
        push_x(vec(0,0,0,0,1,0, 0,0,0,0,1));
      end
      C_STORE: begin
        push_x(vec(0,0,0,0,0,0, 2,1,0,0,0));
        for (int i = 0; i < mw; i++) push(vec(1,1,0,0,0,0, 0,0,0,0,0), 1'b0);
        push(vec(1,1,0,0,0,0, 0,0,0,0,0), 1'b1);
      end
      C_BR:    push_x(vec(0,0,0,taken,0,0, 2,0,1,1,0));
      C_JAL:   push_x(vec(0,0,0,1,1,0, 0,0,0,1,2));
      default: push_x(vec(0,0,0,1,1,0, 2,1,0,2,2));
    endcase
  endtask

  // Plays the queued trace (at most limit cycles if limit >= 0), comparing every cycle
  task automatic run(input string tag, input int limit);
    int n = 0;
    while (q_v.size() > 0 && (limit < 0 || n < limit)) begin
      logic [17:0] v;
      v = q_v.pop_front();
      mem_ready = q_r.pop_front();
      @(negedge clk);
      check({tag, "_vec"}, 32'(dut_vec()), 32'(v));
      check({tag, "_instret"}, 32'(instret), model_cnt % (1 << CW));
      @(posedge clk);
      #1;
      n++;
    end
    q_v.delete();
    q_r.delete();
  endtask

  task automatic set_operands(input logic [31:0] a, input logic [31:0] b);
    alu_zero = (a == b);
    alu_lt   = ($signed(a) < $signed(b));
    alu_ltu  = (a < b);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check("rst_vec", 32'(dut_vec()), 32'd0);
      check("rst_instret", 32'(instret), 32'd0);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    model_cnt = 0;
  endtask

  initial begin
    logic [31:0] a, b;
    int cls, fw, mw;
    logic [2:0] f3;
    bit b5;
    int br_f3[6] = '{0, 1, 4, 5, 6, 7};

    reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    alu_zero = 1'b0; alu_lt = 1'b0; alu_ltu = 1'b0; mem_ready = 1'b1;
    do_reset(2);

    // ADD x3,x1,x2
    opcode = 7'b0110011; funct3 = 3'd0; funct7b5 = 1'b0;
    build(C_R, 3'd0, 1'b0, 1'b0, 0, 0);
    run("add", -1);
    model_cnt++;

    // LW with two wait cycles in MEM_RD
    opcode = 7'b0000011; funct3 = 3'd2; funct7b5 = 1'b0;
    build(C_LOAD, 3'd2, 1'b0, 1'b0, 0, 2);
    run("lw_wait", -1);
    model_cnt++;

    // BEQ taken then not taken
    opcode = 7'b1100011; funct3 = 3'd0;
    set_operands(32'd7, 32'd7);
    build(C_BR, 3'd0, 1'b0, 1'b1, 0, 0);
    run("beq_t", -1);
    model_cnt++;
    set_operands(32'd7, 32'd9);
    build(C_BR, 3'd0, 1'b0, 1'b0, 0, 0);
    run("beq_nt", -1);
    model_cnt++;

    for (int n = 0; n < 200; n++) begin
      cls = $urandom_range(0, 8);
      f3  = 3'($urandom_range(0, 7));
      if (cls == C_BR) f3 = 3'(br_f3[$urandom_range(0, 5)]);
      b5  = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      opcode = opcode_of(cls); funct3 = f3; funct7b5 = b5;
      set_operands(a, b);
      build(cls, f3, b5, ref_taken(f3, a, b), fw, mw);
      run("rand", -1);
      model_cnt++;
    end

    // Reset during a MEM_WR wait: trace stops after fetch, decode, addr and one wait cycle
    opcode = 7'b0100011; funct3 = 3'd2; funct7b5 = 1'b0;
    build(C_STORE, 3'd2, 1'b0, 1'b0, 0, 3);
    run("sw_pre", 4);
    do_reset(1);
    opcode = 7'b0110011; funct3 = 3'd7; funct7b5 = 1'b0;
    build(C_R, 3'd7, 1'b0, 1'b0, 0, 0);
    run("after_rst", -1);
    model_cnt++;

    // Illegal opcode 0x7F: trap from the third cycle, sticky, no enables
    opcode = 7'h7F; funct3 = 3'd0;
    push(vec(1,0,1,1,0,0, 0,2,0,0,0), 1'b1);
    push_x(vec(0,0,0,0,0,0, 1,1,0,0,0));
    for (int i = 0; i < 6; i++) push_x(vec(0,0,0,0,0,1, 0,0,0,0,0));
    run("trap_op", -1);
    do_reset(1);

    // Branch with reserved funct3 traps after the BRANCH cycle without retiring
    opcode = 7'b1100011; funct3 = 3'd2;
    set_operands(32'd1, 32'd1);
    push(vec(1,0,1,1,0,0, 0,2,0,0,0), 1'b1);
    push_x(vec(0,0,0,0,0,0, 1,1,0,0,0));
    push_x(vec(0,0,0,0,0,0, 2,0,1,1,0));
    for (int i = 0; i < 3; i++) push_x(vec(0,0,0,0,0,1, 0,0,0,0,0));
    run("trap_br", -1);
    do_reset(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
